// File: rtl/proc_pkg.sv
// Shared definitions for the memory-stage controller.
//   OPC_LW / OPC_SW : opcode field values (xm_ins[31:27]) of loads and stores
//   state_e         : controller state encoding (ST_IDLE=0, ST_BUSY=1)
package proc_pkg;

  localparam logic [4:0] OPC_LW = 5'b01000;
  localparam logic [4:0] OPC_SW = 5'b00111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/acknowledge bus.
//   mem_req/mem_we/mem_addr/mem_wdata : request, driven by the controller (master)
//   mem_ack/mem_rdata                 : 1-cycle completion pulse and load data (slave)
interface mem_stage_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mw_reg.sv
// Memory/writeback pipeline register bank.
//   clk, clr_n        : clock, async active-low reset
//   load              : capture o/d/ins/ovf this edge
//   valid             : next value of mw_valid (updated every edge)
//   o, d, ins, ovf    : incoming ALU result, load data, instruction, overflow
//   mw_*              : registered outputs
module mw_reg (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        load,
  input  logic        valid,
  input  logic [31:0] o,
  input  logic [31:0] d,
  input  logic [31:0] ins,
  input  logic        ovf,
  output logic        mw_valid,
  output logic [31:0] mw_o,
  output logic [31:0] mw_d,
  output logic [31:0] mw_ins,
  output logic        mw_ovf
);

  // Valid is rewritten every edge so bubbles clear it; the payload only
  // moves when something actually retires.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      mw_valid <= 1'b0;
      mw_o     <= '0;
      mw_d     <= '0;
      mw_ins   <= '0;
      mw_ovf   <= 1'b0;
    end else begin
      mw_valid <= valid;
      if (load) begin
        mw_o   <= o;
        mw_d   <= d;
        mw_ins <= ins;
        mw_ovf <= ovf;
      end
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller behind the XM pipeline register.
//   clk, clr_n          : clock, async active-low reset
//   xm_o/xm_b/xm_ins/xm_ovf : XM register contents (address, store data, instr, ovf)
//   flush               : kill the XM instruction (only honoured in IDLE)
//   stall               : combinational hold for PC/FD/DX/XM
//   mem                 : data-memory req/ack bus (master side)
//   mw_*                : MW register outputs with valid flag
//   stall_count         : saturating count of stalled cycles
module mem_stage_ctrl
  import proc_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                    clk,
  input  logic                    clr_n,
  input  logic [31:0]             xm_o,
  input  logic [31:0]             xm_b,
  input  logic [31:0]             xm_ins,
  input  logic                    xm_ovf,
  input  logic                    flush,
  output logic                    stall,
  mem_stage_ctrl_if.master        mem,
  output logic                    mw_valid,
  output logic [31:0]             mw_o,
  output logic [31:0]             mw_d,
  output logic [31:0]             mw_ins,
  output logic                    mw_ovf,
  output logic [31:0]             stall_count
);

  state_e      state, state_nxt;
  logic        is_lw, is_sw, is_mem;
  logic        issue, done;
  logic        mw_load, mw_vld;
  logic [31:0] mw_d_in;

  assign is_lw  = (xm_ins[31:27] == OPC_LW);
  assign is_sw  = (xm_ins[31:27] == OPC_SW);
  assign is_mem = is_lw | is_sw;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // stall deliberately ignores flush: a memory op in IDLE holds XM for the
  // decode cycle whether or not it is being killed.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    issue     = 1'b0;
    done      = 1'b0;
    mw_load   = 1'b0;
    mw_vld    = 1'b0;
    mw_d_in   = '0;
    case (state)
      ST_IDLE: begin
        stall = is_mem;
        if (!flush) begin
          if (is_mem) begin
            issue     = 1'b1;
            state_nxt = ST_BUSY;
          end else begin
            mw_load = 1'b1;
            mw_vld  = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        // The ack cycle releases the stall so XM advances on the same edge
        // that retires the access.
        stall = ~mem.mem_ack;
        if (mem.mem_ack) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
          mw_load   = 1'b1;
          mw_vld    = 1'b1;
          if (is_lw) mw_d_in = mem.mem_rdata;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else if (issue) begin
      mem.mem_req   <= 1'b1;
      mem.mem_we    <= is_sw;
      mem.mem_addr  <= xm_o[ADDR_W-1:0];
      mem.mem_wdata <= xm_b;
    end else if (done) begin
      mem.mem_req   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)                             stall_count <= '0;
    else if (stall && stall_count != '1)    stall_count <= stall_count + 32'd1;
  end

  mw_reg u_mw_reg (
    .clk      (clk),
    .clr_n    (clr_n),
    .load     (mw_load),
    .valid    (mw_vld),
    .o        (xm_o),
    .d        (mw_d_in),
    .ins      (xm_ins),
    .ovf      (xm_ovf),
    .mw_valid (mw_valid),
    .mw_o     (mw_o),
    .mw_d     (mw_d),
    .mw_ins   (mw_ins),
    .mw_ovf   (mw_ovf)
  );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

  localparam logic [4:0] LW  = 5'b01000;
  localparam logic [4:0] SW  = 5'b00111;
  localparam logic [4:0] ADD = 5'b00000;

  logic        clk = 1'b0;
  logic        clr_n;
  logic [31:0] xm_o, xm_b, xm_ins;
  logic        xm_ovf, flush;
  logic        stall;
  logic        mw_valid, mw_ovf;
  logic [31:0] mw_o, mw_d, mw_ins, stall_count;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] mcnt   = 0;   // reference stall counter

  mem_stage_ctrl_if #(.ADDR_W(32)) mif ();

  mem_stage_ctrl #(.ADDR_W(32)) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .xm_o        (xm_o),
    .xm_b        (xm_b),
    .xm_ins      (xm_ins),
    .xm_ovf      (xm_ovf),
    .flush       (flush),
    .stall       (stall),
    .mem         (mif),
    .mw_valid    (mw_valid),
    .mw_o        (mw_o),
    .mw_d        (mw_d),
    .mw_ins      (mw_ins),
    .mw_ovf      (mw_ovf),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running want done");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] mk(input logic [4:0] opc);
    logic [31:0] r;
    r = $urandom();
    return {opc, r[26:0]};
  endfunction

  // Advance one clock; the reference counter counts cycles the bench
  // expects to be stalled.
  task automatic tick(input bit exp_stall);
    if (exp_stall && mcnt != 32'hFFFF_FFFF) mcnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr_n = 1'b0; flush = 1'b0; xm_ovf = 1'b0;
    xm_o = '0; xm_b = '0; xm_ins = mk(ADD);
    mif.mem_ack = 1'b0; mif.mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if ({mw_valid, mw_ovf, mif.mem_req, mif.mem_we} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {mw_valid, mw_ovf, mif.mem_req, mif.mem_we}); end
    n_chk++; if ({mw_o, mw_d, mw_ins, mif.mem_addr, mif.mem_wdata, stall_count} !== '0) begin n_fail++; $display("FAIL reset_regs: got nonzero want all zero"); end
    clr_n = 1'b1;
    mcnt  = 0;
    // Start a load, then pull reset in the middle of BUSY.
    xm_ins = mk(LW); xm_o = 32'h40; #1;
    tick(1);
    n_chk++; if (mif.mem_req !== 1'b1) begin n_fail++; $display("FAIL reset_pre_req: got %b want 1", mif.mem_req); end
    tick(1);
    #2 clr_n = 1'b0;
    #1;
    n_chk++; if ({mif.mem_req, mif.mem_we, mw_valid, mw_ovf} !== 4'b0) begin n_fail++; $display("FAIL reset_async_flags: got %b want 0000", {mif.mem_req, mif.mem_we, mw_valid, mw_ovf}); end
    n_chk++; if ({mif.mem_addr, stall_count, mw_o, mw_d, mw_ins} !== '0) begin n_fail++; $display("FAIL reset_async_regs: got nonzero want all zero"); end
    mcnt = 0;
    xm_ins = mk(ADD); xm_o = 32'd5; #1;
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_idle_stall: got %b want 0", stall); end
    @(negedge clk);
    clr_n = 1'b1;
    tick(0);
    n_chk++; if (mw_valid !== 1'b1 || mw_o !== 32'd5) begin n_fail++; $display("FAIL reset_add: got v=%b o=%h want v=1 o=5", mw_valid, mw_o); end
  endtask

  task automatic test_lw();
    logic [31:0] ins;
    ins = mk(LW);
    xm_ins = ins; xm_o = 32'h10; xm_b = $urandom(); xm_ovf = 1'b0; flush = 1'b0;
    mif.mem_ack = 1'b0; #1;
    n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lw_decode_stall: got %b want 1", stall); end
    tick(1);
    for (int i = 0; i < 3; i++) begin
      n_chk++; if ({mif.mem_req, mif.mem_we, mw_valid, stall} !== 4'b1001 || mif.mem_addr !== 32'h10) begin n_fail++; $display("FAIL lw_busy%0d: got req/we/v/st=%b addr=%h want 1001 addr=10", i, {mif.mem_req, mif.mem_we, mw_valid, stall}, mif.mem_addr); end
      tick(1);
    end
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'hDEAD_BEEF; #1;
    n_chk++; if (stall !== 1'b0 || mif.mem_req !== 1'b1) begin n_fail++; $display("FAIL lw_ack_cycle: got st=%b req=%b want st=0 req=1", stall, mif.mem_req); end
    tick(0);
    mif.mem_ack = 1'b0; xm_ins = mk(ADD);
    n_chk++; if (mif.mem_req !== 1'b0 || mw_valid !== 1'b1) begin n_fail++; $display("FAIL lw_retire_flags: got req=%b v=%b want req=0 v=1", mif.mem_req, mw_valid); end
    n_chk++; if (mw_d !== 32'hDEAD_BEEF || mw_o !== 32'h10 || mw_ins !== ins) begin n_fail++; $display("FAIL lw_retire_data: got d=%h o=%h ins=%h want d=deadbeef o=10 ins=%h", mw_d, mw_o, mw_ins, ins); end
    n_chk++; if (stall_count !== mcnt || mcnt !== 32'd4) begin n_fail++; $display("FAIL lw_stall_count: got %0d want 4 (model %0d)", stall_count, mcnt); end
  endtask

  task automatic test_sw();
    xm_ins = mk(SW); xm_o = 32'd4; xm_b = 32'd7; xm_ovf = 1'b1; flush = 1'b0;
    mif.mem_ack = 1'b0; #1;
    n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL sw_decode_stall: got %b want 1", stall); end
    tick(1);
    n_chk++; if ({mif.mem_req, mif.mem_we} !== 2'b11 || mif.mem_wdata !== 32'd7 || mif.mem_addr !== 32'd4) begin n_fail++; $display("FAIL sw_issue: got req/we=%b wd=%h a=%h want 11 wd=7 a=4", {mif.mem_req, mif.mem_we}, mif.mem_wdata, mif.mem_addr); end
    mif.mem_ack = 1'b1; mif.mem_rdata = $urandom(); #1;
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL sw_ack_stall: got %b want 0", stall); end
    tick(0);
    mif.mem_ack = 1'b0; xm_ins = mk(ADD); xm_ovf = 1'b0;
    n_chk++; if (mw_valid !== 1'b1 || mw_d !== 32'd0 || mw_ovf !== 1'b1 || mif.mem_req !== 1'b0) begin n_fail++; $display("FAIL sw_retire: got v=%b d=%h ovf=%b req=%b want v=1 d=0 ovf=1 req=0", mw_valid, mw_d, mw_ovf, mif.mem_req); end
    n_chk++; if (stall_count !== mcnt) begin n_fail++; $display("FAIL sw_stall_count: got %0d want %0d", stall_count, mcnt); end
  endtask

  task automatic test_flush();
    logic [31:0] rd;
    xm_ins = mk(LW); xm_o = 32'h80; flush = 1'b1; mif.mem_ack = 1'b0; #1;
    n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL flush_idle_stall: got %b want 1", stall); end
    tick(1);
    n_chk++; if (mif.mem_req !== 1'b0 || mw_valid !== 1'b0) begin n_fail++; $display("FAIL flush_idle: got req=%b v=%b want 0 0", mif.mem_req, mw_valid); end
    // Flush raised after the access is issued must not abort it.
    flush = 1'b0; xm_ins = mk(LW); xm_o = 32'h84; #1;
    tick(1);
    flush = 1'b1; #1;
    n_chk++; if (stall !== 1'b1 || mif.mem_req !== 1'b1) begin n_fail++; $display("FAIL flush_busy_hold: got st=%b req=%b want 1 1", stall, mif.mem_req); end
    tick(1);
    rd = $urandom();
    mif.mem_ack = 1'b1; mif.mem_rdata = rd; #1;
    tick(0);
    mif.mem_ack = 1'b0; flush = 1'b0; xm_ins = mk(ADD);
    n_chk++; if (mw_valid !== 1'b1 || mw_d !== rd || mif.mem_req !== 1'b0) begin n_fail++; $display("FAIL flush_busy_retire: got v=%b d=%h req=%b want v=1 d=%h req=0", mw_valid, mw_d, mif.mem_req, rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, ins_sw;
    rd = $urandom(); ins_sw = mk(SW);
    xm_ins = mk(LW); xm_o = 32'h20; flush = 1'b0; mif.mem_ack = 1'b0; #1;
    tick(1);
    tick(1);
    mif.mem_ack = 1'b1; mif.mem_rdata = rd; #1;
    tick(0);
    mif.mem_ack = 1'b0;
    n_chk++; if (mw_valid !== 1'b1 || mw_d !== rd) begin n_fail++; $display("FAIL b2b_lw_retire: got v=%b d=%h want v=1 d=%h", mw_valid, mw_d, rd); end
    xm_ins = ins_sw; xm_o = 32'h24; xm_b = $urandom(); #1;
    n_chk++; if (mif.mem_req !== 1'b0 || stall !== 1'b1) begin n_fail++; $display("FAIL b2b_gap: got req=%b st=%b want req=0 st=1", mif.mem_req, stall); end
    tick(1);
    n_chk++; if (mw_valid !== 1'b0 || mif.mem_req !== 1'b1 || mif.mem_we !== 1'b1) begin n_fail++; $display("FAIL b2b_bubble: got v=%b req=%b we=%b want 0 1 1", mw_valid, mif.mem_req, mif.mem_we); end
    mif.mem_ack = 1'b1; #1;
    tick(0);
    mif.mem_ack = 1'b0; xm_ins = mk(ADD);
    n_chk++; if (mw_valid !== 1'b1 || mw_ins !== ins_sw || mw_d !== 32'd0) begin n_fail++; $display("FAIL b2b_sw_retire: got v=%b ins=%h d=%h want v=1 ins=%h d=0", mw_valid, mw_ins, mw_d, ins_sw); end
  endtask

  task automatic test_spurious_ack();
    logic [31:0] o;
    for (int i = 0; i < 2; i++) begin
      o = $urandom();
      xm_ins = mk(ADD); xm_o = o; flush = 1'b0; mif.mem_ack = (i == 0); #1;
      n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL spur_stall%0d: got %b want 0", i, stall); end
      tick(0);
      n_chk++; if (mw_valid !== 1'b1 || mw_o !== o || mif.mem_req !== 1'b0) begin n_fail++; $display("FAIL spur_retire%0d: got v=%b o=%h req=%b want v=1 o=%h req=0", i, mw_valid, mw_o, mif.mem_req, o); end
    end
    mif.mem_ack = 1'b0;
    n_chk++; if (stall_count !== mcnt) begin n_fail++; $display("FAIL spur_stall_count: got %0d want %0d", stall_count, mcnt); end
  endtask

  // Random instruction stream: each instruction's fate follows from its kind,
  // whether it is flushed at decode, and how long the memory takes.
  task automatic test_random();
    logic [31:0] ins, o, b, rd, exp_d;
    logic [4:0]  opc;
    logic        ovf, fl, mem_op, is_store;
    int          kind, lat;
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 2);
      do opc = 5'($urandom()); while (kind == 0 && (opc == LW || opc == SW));
      if (kind == 1) opc = LW;
      if (kind == 2) opc = SW;
      ins = mk(opc); o = $urandom(); b = $urandom(); ovf = 1'($urandom());
      fl = ($urandom_range(0, 5) == 0);
      lat = $urandom_range(0, 3);
      mem_op = (kind != 0); is_store = (kind == 2);
      xm_ins = ins; xm_o = o; xm_b = b; xm_ovf = ovf; flush = fl;
      mif.mem_ack = 1'($urandom()); #1;
      n_chk++; if (stall !== mem_op) begin n_fail++; $display("FAIL rnd%0d_decode_stall: got %b want %b", n, stall, mem_op); end
      tick(mem_op);
      if (fl) begin
        n_chk++; if (mw_valid !== 1'b0 || mif.mem_req !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_flush: got v=%b req=%b want 0 0", n, mw_valid, mif.mem_req); end
      end else if (!mem_op) begin
        n_chk++; if (mw_valid !== 1'b1 || mw_o !== o || mw_d !== 32'd0 || mw_ins !== ins || mw_ovf !== ovf) begin n_fail++; $display("FAIL rnd%0d_alu: got v=%b o=%h d=%h ins=%h ovf=%b want 1 %h 0 %h %b", n, mw_valid, mw_o, mw_d, mw_ins, mw_ovf, o, ins, ovf); end
      end else begin
        n_chk++; if (mw_valid !== 1'b0 || mif.mem_req !== 1'b1 || mif.mem_we !== is_store || mif.mem_addr !== o || mif.mem_wdata !== b) begin n_fail++; $display("FAIL rnd%0d_issue: got v=%b req=%b we=%b a=%h wd=%h want 0 1 %b %h %h", n, mw_valid, mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_wdata, is_store, o, b); end
        flush = 1'($urandom()); mif.mem_ack = 1'b0;
        for (int k = 0; k < lat; k++) begin
          #1;
          n_chk++; if (stall !== 1'b1 || mif.mem_req !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_wait%0d: got st=%b req=%b want 1 1", n, k, stall, mif.mem_req); end
          tick(1);
        end
        rd = $urandom();
        mif.mem_ack = 1'b1; mif.mem_rdata = rd; #1;
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_ack_stall: got %b want 0", n, stall); end
        tick(0);
        mif.mem_ack = 1'b0;
        exp_d = is_store ? 32'd0 : rd;
        n_chk++; if (mw_valid !== 1'b1 || mw_d !== exp_d || mw_o !== o || mw_ins !== ins || mif.mem_req !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_retire: got v=%b d=%h o=%h req=%b want 1 %h %h 0", n, mw_valid, mw_d, mw_o, mif.mem_req, exp_d, o); end
      end
    end
    flush = 1'b0; mif.mem_ack = 1'b0; xm_ins = mk(ADD);
    n_chk++; if (stall_count !== mcnt) begin n_fail++; $display("FAIL rnd_stall_count: got %0d want %0d", stall_count, mcnt); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_flush();
    test_back_to_back();
    test_spurious_ack();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
